// File: rtl/dram_req_queue.sv
// dram_req_queue: in-order request buffer in front of dram_ctrl.
// L2 requests are accepted over a valid/ready handshake, stored in a small
// FIFO (NOPs are accepted but never stored), then issued one at a time to
// the controller over cmd_req/cmd_ack with at least one idle cycle between
// consecutive commands.
//
// Handshakes:
//   l2 side : a request transfers on a rising edge where l2_req_valid and
//             l2_req_ready are both 1; ready depends only on occupancy.
//   cmd side: cmd_req is held with stable fields until a rising edge with
//             cmd_ack=1; cmd_ack is ignored whenever cmd_req is 0.
module dram_req_queue #(
   parameter int L2_REQ_WIDTH = 22,
   parameter int NUM_OF_BANKS = 8,
   parameter int NUM_OF_ROWS  = 128,
   parameter int NUM_OF_COLS  = 8,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                            clk,
   input  logic                            rst_b,
   input  logic                            l2_req_valid,
   input  logic [L2_REQ_WIDTH-1:0]         l2_req_instr,
   output logic                            l2_req_ready,
   output logic [1:0]                      cmd,
   output logic                            cmd_req,
   input  logic                            cmd_ack,
   output logic [$clog2(NUM_OF_BANKS)-1:0] bank_id,
   output logic [$clog2(NUM_OF_ROWS)-1:0]  row_id,
   output logic [$clog2(NUM_OF_COLS)-1:0]  col_id,
   output logic [$clog2(FIFO_DEPTH):0]     q_count,
   output logic [1:0]                      fsm_state
);

   localparam int BANK_W   = $clog2(NUM_OF_BANKS);
   localparam int ROW_W    = $clog2(NUM_OF_ROWS);
   localparam int COL_W    = $clog2(NUM_OF_COLS);
   localparam int PTR_W    = $clog2(FIFO_DEPTH);
   localparam int CNT_W    = PTR_W + 1;
   localparam int ENTRY_W  = 2 + BANK_W + ROW_W + COL_W;
   localparam int CMD_LSB  = L2_REQ_WIDTH - 2;
   localparam int BANK_LSB = CMD_LSB - BANK_W;
   localparam int ROW_LSB  = BANK_LSB - ROW_W;
   localparam int COL_LSB  = ROW_LSB - COL_W;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t                 state, state_nxt;
   logic [ENTRY_W-1:0]     mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       count;
   logic [ENTRY_W-1:0]     head;
   logic                   push, pop, load;
   logic                   rsvd_unused;

   // Reserved request bits carry no meaning for this block.
   assign rsvd_unused = ^l2_req_instr[COL_LSB-1:0];

   // Enqueue side: ready from occupancy only; NOPs complete the handshake but are not stored.
   assign l2_req_ready = (count != FULL_CNT);
   assign push = l2_req_valid && l2_req_ready && (l2_req_instr[L2_REQ_WIDTH-1 -: 2] != 2'b00);
   assign head = mem[rd_ptr];
   assign q_count = count;

   // FIFO storage; written only on a push, so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= l2_req_instr[L2_REQ_WIDTH-1 -: ENTRY_W];
      end
   end

   // Pointers wrap naturally (depth is a power of 2); occupancy tells full from empty.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   // Issue FSM next-state: IDLE waits for an entry, REQ waits for ack, GAP forces one low cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = REQ;
         REQ:     if (cmd_ack)     state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Issue FSM outputs: request level, head pop on ack, field load on leaving IDLE.
   always_comb begin
      cmd_req   = (state == REQ);
      pop       = (state == REQ) && cmd_ack;
      load      = (state == IDLE) && (count != '0);
      fsm_state = state;
   end

   // Field registers: captured from the head when a command starts, held otherwise.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         cmd     <= '0;
         bank_id <= '0;
         row_id  <= '0;
         col_id  <= '0;
      end else if (load) begin
         cmd     <= head[ENTRY_W-1 -: 2];
         bank_id <= head[BANK_LSB-COL_LSB +: BANK_W];
         row_id  <= head[ROW_LSB-COL_LSB +: ROW_W];
         col_id  <= head[0 +: COL_W];
      end
   end

endmodule
